// File: rtl/ex_div_seq.sv
// Iterative restoring divider for EX-stage DIV/DIVU: one quotient bit per cycle,
// returning {remainder, quotient} and requesting a pipeline stall while busy.
module ex_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] BYZERO = 2'd2;
  localparam logic [1:0] END    = 2'd3;

  localparam logic [5:0] LAST_CNT = 6'd32;

  logic [1:0]  state;
  logic [5:0]  cnt;

  // Datapath registers: dvd shifts the dividend out MSB-first and the quotient in LSB-first.
  logic [31:0] dvd;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic        neg_q;
  logic        neg_r;

  logic [32:0] partial;
  logic        sub_ok;
  logic [31:0] rem_nxt;
  logic        take_op;
  logic        iterate;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return neg_if(v, sgn & v[31]);
  endfunction

  // When the trial subtraction succeeds the true difference is below the
  // divisor, so a 32-bit modular subtract yields it exactly.
  assign partial = {rem, dvd[31]};
  assign sub_ok  = (partial >= {1'b0, dsr});
  assign rem_nxt = sub_ok ? (partial[31:0] - dsr) : partial[31:0];

  assign take_op = (state == FREE) && start_i && !annul_i && (opdata2_i != 32'd0);
  assign iterate = (state == BUSY) && !annul_i && (cnt != LAST_CNT);

  assign stallreq_o = start_i & ~annul_i & ~ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= BYZERO;
            end else begin
              state <= BUSY;
              cnt   <= 6'd0;
            end
          end
        end
        BUSY: begin
          if (annul_i) begin
            state    <= FREE;
            cnt      <= 6'd0;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end else if (cnt == LAST_CNT) begin
            result_o <= {neg_if(rem, neg_r), neg_if(dvd, neg_q)};
            ready_o  <= 1'b1;
            cnt      <= 6'd0;
            state    <= END;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        BYZERO: begin
          result_o <= 64'd0;
          state    <= annul_i ? FREE : END;
        end
        default: begin
          // The divide-by-zero path arrives here with ready still low and raises it now.
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end else begin
            ready_o <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (take_op) begin
      dvd   <= mag(opdata1_i, signed_div_i);
      dsr   <= mag(opdata2_i, signed_div_i);
      rem   <= 32'd0;
      neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
      neg_r <= signed_div_i & opdata1_i[31];
    end else if (iterate) begin
      rem <= rem_nxt;
      dvd <= {dvd[30:0], sub_ok};
    end
  end

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed bench for ex_div_seq: per-cycle checker against an arithmetic model,
// plus literal expected results, latency and stall-length checks per transaction.
module tb_ex_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [63:0] cur_exp  = 64'd0;

  ex_div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: magnitude divide, then apply the sign rules.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return 64'd0;
    ua = (sgn && a[31]) ? -a : a;
    ub = (sgn && b[31]) ? -b : b;
    q  = ua / ub;
    r  = ua % ub;
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  // Per-cycle checker: stall rule, and result is either the model value or zero.
  always @(posedge clk) begin
    #1;
    chk("stallreq", {63'd0, stallreq}, {63'd0, start & ~annul & ~ready});
    if (ready) chk("result_model", result, cur_exp);
    else       chk("result_idle", result, 64'd0);
  end

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] lit, input string name);
    int n;
    int scnt;
    int lat;
    @(negedge clk);
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    cur_exp = model(sgn, a, b);
    lat = (b == 32'd0) ? 2 : 33;
    #1;
    scnt = stallreq ? 1 : 0;
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      op1 = ~a;
      op2 = b + 32'd5;
      if (ready) break;
      if (stallreq) scnt++;
    end
    chk({name, "_latency"}, 64'(n - 1), 64'(lat));
    chk({name, "_stall_len"}, 64'(scnt), 64'(lat + 1));
    chk({name, "_result"}, result, lit);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_hold_ready"}, {63'd0, ready}, 64'd1);
      chk({name, "_hold_result"}, result, lit);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_drop_ready"}, {63'd0, ready}, 64'd0);
    chk({name, "_drop_result"}, result, 64'd0);
  endtask

  initial begin
    rst = 1'b1; signed_div = 1'b0; op1 = 32'd0; op2 = 32'd0; start = 1'b0; annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_stall", {63'd0, stallreq}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(1'b0, 32'd7,          32'd2,          64'h00000001_00000003, "divu_7_2");
    run_div(1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, "div_m7_2");
    run_div(1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, "div_7_m2");
    run_div(1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, "div_min_m1");
    run_div(1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, "divu_max_1");
    run_div(1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, "divu_big_divisor");
    run_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, "div_m100_m7");
    run_div(1'b0, 32'h12345678,   32'h00000100,   64'h00000078_00123456, "divu_shift");
    run_div(1'b0, 32'd5,          32'd0,          64'd0,                 "divu_by_zero");
    run_div(1'b1, 32'hFFFFFFF0,   32'd0,          64'd0,                 "div_by_zero");

    // Annul on the tenth BUSY cycle, then restart immediately.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd50; op2 = 32'd3; start = 1'b1; annul = 1'b0;
    cur_exp = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_ready", {63'd0, ready}, 64'd0);
    chk("annul_result", result, 64'd0);
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu_after_annul");

    // Reset pulsed mid-BUSY, then the same fresh division.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd9; start = 1'b1; annul = 1'b0;
    cur_exp = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ready", {63'd0, ready}, 64'd0);
    chk("rst_mid_result", result, 64'd0);
    rst = 1'b0;
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu_after_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got %0d checks, expected completion", chk_cnt);
    $fatal(1);
  end

endmodule
